uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
Round-robin arbiter/sequencer sharing one UART transmitter among NUM_REQ byte requesters. Each requester presents a byte with valid/ready. The block picks a winner, launches the byte into the transmitter with a one-cycle start pulse, and tracks the transmitter busy flag to frame completion. A winner may keep the grant for up to MAX_BURST consecutive bytes. Sits between protocol clients (command responders, loopback, status reporters) and the UART serialiser on the clk_fpga domain.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
MAX_BURST, 4, max consecutive bytes per grant (>=1)
ACK_TIMEOUT, 1024, cycles allowed from tx_start to tx_busy rise (used only with UART_TX_ARB_TIMEOUT_EN)

Ports:
clk_fpga  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
req_valid  in  NUM_REQ  per-requester byte-available
req_data  in  8*NUM_REQ  requester i byte on bits [8*i+7:8*i]
req_ready  out  NUM_REQ  one-cycle consume pulse, one-hot
tx_busy  in  1  transmitter serialising a frame
tx_start  out  1  one-cycle launch pulse to transmitter
tx_data  out  8  byte to transmit, stable from tx_start until next launch
grant_valid  out  1  a requester currently owns the transmitter
grant_id  out  clog2(NUM_REQ)  current owner index
timeout_err  out  1  one-cycle pulse on ack timeout (0 when feature off)

Behaviour:
- Reset (reset=0, async): state=IDLE, rr_ptr=0, burst_cnt=0, all outputs 0 immediately; any in-flight grant abandoned, no pulse emitted.
- All outputs registered. States: IDLE, START, WAIT_ACK, WAIT_DONE.
- IDLE: if any req_valid=1 and tx_busy=0, winner = first index at or after rr_ptr (wrapping mod NUM_REQ) with valid=1; register grant_id=winner, grant_valid=1, tx_data=req_data[winner], burst_cnt=0; go START. No valid, or tx_busy=1, -> stay IDLE.
- START (exactly one cycle): tx_start=1, req_ready[grant_id]=1; go WAIT_ACK. Requester must hold valid/data stable until it sees req_ready; byte already sampled on the entry edge.
- WAIT_ACK: wait tx_busy=1 -> WAIT_DONE. If tx_busy already 1 in first WAIT_ACK cycle, move next edge.
- WAIT_DONE: on tx_busy=0: if req_valid[grant_id]=1 and burst_cnt<MAX_BURST-1, sample next byte, burst_cnt+1, go START (same owner, no re-arbitration); else rr_ptr=(grant_id+1) mod NUM_REQ, grant_valid=0, go IDLE.
- Minimum spacing between tx_start pulses = 3 cycles plus transmitter busy time.
- MAX_BURST=1: every byte re-arbitrates.
- Requester dropping valid in WAIT_ACK/WAIT_DONE: sampled byte still sent; burst ends at WAIT_DONE.
- Simultaneous requests: strict rotating priority from rr_ptr; with all NUM_REQ valid continuously, service order 0,1,2,3,0,... in groups of MAX_BURST bytes.
- req_ready never asserted for a non-owner; at most one bit high; never high outside START.
- Changes to req_data of non-owners never affect tx_data.
- rr_ptr wraps NUM_REQ-1 -> 0.

Optional Feature:
UART_TX_ARB_TIMEOUT_EN: defined -> counter runs in WAIT_ACK; if tx_busy not seen within ACK_TIMEOUT cycles of tx_start, pulse timeout_err one cycle, drop grant, rr_ptr=grant_id+1, return to IDLE (byte lost, req_ready already given). Undefined -> no counter, WAIT_ACK waits indefinitely, timeout_err tied 0.

Test Plan:
- Reset 5 cycles, req_valid[2]=1 data 0x5A, busy model 10 cycles -> one req_ready[2] pulse, tx_start with tx_data=0x5A, grant_id=2, then grant_valid=0.
- req_valid=4'b1111 held, MAX_BURST=1, bytes 0x10/0x11/0x12/0x13 -> tx_data sequence 0x10,0x11,0x12,0x13,0x10; rr_ptr wraps.
- req_valid[1] held, MAX_BURST=4, req_valid[3] also held -> 4 bytes from 1, then grant to 3, then back to 1.
- tx_busy stuck at 1 from reset, req_valid[0]=1 -> stays IDLE, no tx_start until tx_busy falls, then launch.
- Timeout build, ACK_TIMEOUT=16, tx_busy never rises -> timeout_err pulse 16 cycles after tx_start, next request served.
- reset asserted in WAIT_DONE mid-burst -> tx_start/req_ready/grant_valid 0 immediately; after release, arbitration restarts from index 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte requesters, bursts up to MAX_BURST.
// Optional feature macro: UART_TX_ARB_TIMEOUT_EN (ack timeout on missing tx_busy).
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_BURST   = 4,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                       clk_fpga,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       tx_busy,
  output logic                       tx_start,
  output logic [7:0]                 tx_data,
  output logic                       grant_valid,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err
);
  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_ACK, S_WAIT_DONE} state_t;

  state_t             r_state;
  logic [IDW-1:0]     r_rr_ptr;
  logic [IDW-1:0]     r_grant_id;
  logic [BW-1:0]      r_burst_cnt;
  logic               r_grant_valid;
  logic               r_tx_start;
  logic [7:0]         r_tx_data;
  logic [NUM_REQ-1:0] r_req_ready;

  logic [IDW-1:0]     w_idx [NUM_REQ];
  logic [IDW-1:0]     w_winner;
  logic               w_any;
  logic [IDW-1:0]     w_next_ptr;
  logic               w_continue;

  // w_idx[k] is the requester k places after rr_ptr, wrapping modulo NUM_REQ.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_idx
    logic [IDW:0] w_sum;
    assign w_sum      = {1'b0, r_rr_ptr} + (IDW+1)'(gi);
    assign w_idx[gi]  = (w_sum >= (IDW+1)'(NUM_REQ)) ? IDW'(w_sum - (IDW+1)'(NUM_REQ))
                                                     : w_sum[IDW-1:0];
  end

  // Scan from the far end so the closest valid requester to rr_ptr wins.
  always_comb begin
    w_winner = '0;
    w_any    = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[w_idx[k]]) begin
        w_winner = w_idx[k];
        w_any    = 1'b1;
      end
    end
  end

  assign w_next_ptr = (r_grant_id == IDW'(NUM_REQ - 1)) ? '0 : r_grant_id + 1'b1;
  assign w_continue = req_valid[r_grant_id] && (r_burst_cnt < BW'(MAX_BURST - 1));

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int ACW = $clog2(ACK_TIMEOUT + 1);
  logic [ACW-1:0] r_ack_cnt;
  logic           r_timeout_err;
  assign timeout_err = r_timeout_err;
`else
  // Without the timeout the ack limit has no effect and WAIT_ACK waits indefinitely.
  if (ACK_TIMEOUT < 0) begin : g_no_timeout
  end
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_fpga or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_grant_id    <= '0;
      r_burst_cnt   <= '0;
      r_grant_valid <= 1'b0;
      r_tx_start    <= 1'b0;
      r_tx_data     <= '0;
      r_req_ready   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_ack_cnt     <= '0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_tx_start    <= 1'b0;
      r_req_ready   <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_any && !tx_busy) begin
            r_grant_id    <= w_winner;
            r_grant_valid <= 1'b1;
            r_tx_data     <= req_data[8*w_winner +: 8];
            r_burst_cnt   <= '0;
            r_tx_start    <= 1'b1;
            r_req_ready   <= NUM_REQ'(1) << w_winner;
            r_state       <= S_START;
          end
        end
        S_START: begin
          r_state   <= S_WAIT_ACK;
`ifdef UART_TX_ARB_TIMEOUT_EN
          r_ack_cnt <= ACW'(1);
`endif
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            r_state <= S_WAIT_DONE;
          end
`ifdef UART_TX_ARB_TIMEOUT_EN
          else if (r_ack_cnt == ACW'(ACK_TIMEOUT - 1)) begin
            r_timeout_err <= 1'b1;
            r_grant_valid <= 1'b0;
            r_rr_ptr      <= w_next_ptr;
            r_state       <= S_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + 1'b1;
          end
`endif
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            if (w_continue) begin
              r_tx_data   <= req_data[8*r_grant_id +: 8];
              r_burst_cnt <= r_burst_cnt + 1'b1;
              r_tx_start  <= 1'b1;
              r_req_ready <= NUM_REQ'(1) << r_grant_id;
              r_state     <= S_START;
            end else begin
              r_rr_ptr      <= w_next_ptr;
              r_grant_valid <= 1'b0;
              r_state       <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_req_ready;
  assign tx_start    = r_tx_start;
  assign tx_data     = r_tx_data;
  assign grant_valid = r_grant_valid;
  assign grant_id    = r_grant_id;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte queues, a randomised transmitter busy model,
// and a transaction-level round-robin/burst reference checked at every tx_start.
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int MB = 4;

  logic            clk_fpga = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_ready;
  logic            tx_busy;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            grant_valid;
  logic [1:0]      grant_id;
  logic            timeout_err;

  always #5 clk_fpga = ~clk_fpga;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .ACK_TIMEOUT(16)) dut (
    .clk_fpga(clk_fpga), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .grant_valid(grant_valid), .grant_id(grant_id), .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // Requester byte queues: valid whenever non-empty, popped when the arbiter consumes.
  logic [7:0] qmem [NR][256];
  int         qh [NR];
  int         qt [NR];

  // Reference model state: rotating pointer, current owner, bytes in current grant.
  int         rr = 0;
  int         own = 0;
  int         burst = 0;
  bit         own_act = 1'b0;
  logic [7:0] last_data = 8'h00;
  int         seq[$];
  int         launches = 0;

  int  b_dly = 0;
  int  b_len = 0;
  bit  busy_force = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int from);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (from + k) % NR;
      if (qh[idx] < qt[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int i = 0; i < NR; i++) if (qh[i] < qt[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic push(input int i, input logic [7:0] b);
    qmem[i][qt[i]] = b;
    qt[i]++;
  endtask

  task automatic step();
    int exp_o;
    logic [7:0] exp_d;
    for (int i = 0; i < NR; i++) begin
      if (qh[i] < qt[i]) begin
        req_valid[i]        = 1'b1;
        req_data[8*i +: 8]  = qmem[i][qh[i]];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[8*i +: 8]  = 8'($urandom);
      end
    end
    @(posedge clk_fpga); #1;
    if (tx_start === 1'b1) begin
      if (own_act && qh[own] < qt[own] && burst < MB - 1) begin
        exp_o = own;
        burst++;
      end else begin
        if (own_act) rr = (own + 1) % NR;
        exp_o = pick(rr);
        burst = 0;
      end
      if (exp_o < 0) begin
        chk("unexpected_launch", {31'b0, tx_start}, 32'd0);
      end else begin
        exp_d = qmem[exp_o][qh[exp_o]];
        chk("grant_id", grant_id, exp_o);
        chk("tx_data", tx_data, exp_d);
        chk("req_ready", req_ready, 32'd1 << exp_o);
        chk("grant_valid", grant_valid, 32'd1);
        own       = exp_o;
        own_act   = 1'b1;
        last_data = exp_d;
        qh[exp_o]++;
        seq.push_back(exp_o);
        launches++;
        $display("launch %0d: owner=%0d data=0x%02h burst_idx=%0d", launches, exp_o, exp_d, burst);
      end
      b_dly = 1 + $urandom_range(0, 2);
      b_len = $urandom_range(1, 5);
    end else begin
      chk("ready_outside_start", req_ready, 32'd0);
    end
    chk("tx_data_hold", tx_data, last_data);
    chk("timeout_err_off", timeout_err, 32'd0);
    if (busy_force) tx_busy = 1'b1;
    else if (b_dly > 0) begin b_dly--; tx_busy = 1'b0; end
    else if (b_len > 0) begin b_len--; tx_busy = 1'b1; end
    else tx_busy = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((pending() || grant_valid === 1'b1) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", {31'b0, n < budget}, 32'd1);
    repeat (3) step();
    chk("idle_after_drain", grant_valid, 32'd0);
    if (own_act) begin
      rr      = (own + 1) % NR;
      own_act = 1'b0;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k0;
    int n;
    int exp_c [11];
    for (int i = 0; i < NR; i++) begin qh[i] = 0; qt[i] = 0; end
    reset     = 1'b0;
    tx_busy   = 1'b1;
    busy_force = 1'b1;
    req_valid = '0;
    req_data  = '0;

    // Reset state, with the transmitter reporting busy from the start.
    repeat (5) @(posedge clk_fpga);
    #1;
    chk("rst_tx_start", tx_start, 32'd0);
    chk("rst_req_ready", req_ready, 32'd0);
    chk("rst_grant_valid", grant_valid, 32'd0);
    chk("rst_grant_id", grant_id, 32'd0);
    chk("rst_tx_data", tx_data, 32'd0);
    reset = 1'b1;

    // Busy stuck high: requester 0 must wait, then launch once busy falls.
    push(0, 8'hC3);
    k0 = seq.size();
    repeat (20) begin
      step();
      chk("no_launch_while_busy", tx_start, 32'd0);
    end
    busy_force = 1'b0;
    drain(200);
    chk("busy_release_count", seq.size() - k0, 32'd1);
    chk("busy_release_data", tx_data, 32'hC3);

    // Single request from requester 2.
    push(2, 8'h5A);
    k0 = seq.size();
    drain(200);
    chk("single_count", seq.size() - k0, 32'd1);
    if (seq.size() > k0) chk("single_owner", seq[k0], 32'd2);
    chk("single_data", tx_data, 32'h5A);

    // Bursts: rr_ptr is 3 here, so 3 gets MAX_BURST bytes, then 1, then 3, then 1.
    exp_c = '{3, 3, 3, 3, 1, 1, 1, 1, 3, 1, 1};
    for (int j = 0; j < 6; j++) push(1, 8'(8'h20 + j));
    for (int j = 0; j < 5; j++) push(3, 8'(8'h30 + j));
    k0 = seq.size();
    drain(600);
    chk("burst_count", seq.size() - k0, 32'd11);
    for (int j = 0; j < 11; j++)
      if (seq.size() > k0 + j) chk("burst_order", seq[k0 + j], exp_c[j]);

    // Randomised rounds.
    for (int r = 0; r < 6; r++) begin
      int total;
      total = 0;
      k0 = seq.size();
      for (int i = 0; i < NR; i++) begin
        n = $urandom_range(0, 7);
        for (int j = 0; j < n; j++) push(i, 8'($urandom));
        total += n;
      end
      drain(3000);
      chk("random_round_count", seq.size() - k0, total);
    end

    // Reset mid-burst: make rr_ptr non-zero first so a stale pointer would be visible.
    push(1, 8'h77);
    drain(200);
    for (int j = 0; j < 4; j++) push(2, 8'(8'h90 + j));
    k0 = launches;
    n = 0;
    while (launches - k0 < 2 && n < 300) begin step(); n++; end
    chk("midburst_reached", {31'b0, n < 300}, 32'd1);
    b_len = 8;
    repeat (3) step();
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tx_start", tx_start, 32'd0);
    chk("async_rst_req_ready", req_ready, 32'd0);
    chk("async_rst_grant_valid", grant_valid, 32'd0);
    chk("async_rst_tx_data", tx_data, 32'd0);
    for (int i = 0; i < NR; i++) begin qh[i] = 0; qt[i] = 0; end
    req_valid = '0;
    b_dly = 0; b_len = 0; tx_busy = 1'b0;
    rr = 0; own_act = 1'b0; burst = 0; last_data = 8'h00;
    repeat (3) begin
      @(posedge clk_fpga); #1;
      chk("rst_hold_tx_start", tx_start, 32'd0);
      chk("rst_hold_grant_valid", grant_valid, 32'd0);
    end
    reset = 1'b1;
    push(3, 8'hA3);
    push(0, 8'hA0);
    k0 = seq.size();
    drain(300);
    chk("restart_count", seq.size() - k0, 32'd2);
    if (seq.size() > k0) chk("restart_from_zero", seq[k0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
